display_scan_ctrl: RTL

Time-multiplexing controller for the 4-digit 7-segment display. It sits directly upstream of the 4:1 nibble mux (`mux_4x1`). It holds the four displayed nibbles in double-buffered registers that drive mux inputs `in0..in3`, and steps the mux select. It also drives the matching digit anode with a blanking guard at the start of each slot, so the display never ghosts.

---
 rtl/display_pkg.sv | 24 ++
 rtl/scan_prescaler.sv | 40 ++++
 rtl/display_scan_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the 4-digit 7-segment scan path.
//   N_DIGITS / NIBBLE_W : display geometry (4 digits of 4-bit nibbles)
//   nibble_t, frame_t   : one digit value / all four digit values packed
//   digit_idx_t         : digit index driven onto the nibble mux select
//   an_onehot()         : anode pattern that lights exactly one digit
package display_pkg;

  localparam int N_DIGITS = 4;
  localparam int NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0]          nibble_t;
  typedef logic [N_DIGITS*NIBBLE_W-1:0] frame_t;
  typedef logic [1:0]                   digit_idx_t;

  // One-hot anode pattern for digit idx, inverted when anodes are active-low.
  function automatic logic [N_DIGITS-1:0] an_onehot(input digit_idx_t idx,
                                                    input logic       active_low);
    logic [N_DIGITS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return active_low ? ~oh : oh;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-DIV slot counter for the display scan.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   enable       : 1 advances the count, 0 holds it
//   cnt          : position inside the current digit slot, 0..DIV-1
//   tc           : high while cnt = DIV-1 and enable = 1 (last cycle of a slot)
module scan_prescaler #(
  parameter  int DIV = 50000,
  localparam int CW  = $clog2(DIV)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_next;

  // Equality against DIV-1 means the counter never runs past the slot, so
  // a non-power-of-two DIV needs no overflow handling.
  assign tc = enable && (cnt == LAST);

  always_comb begin
    cnt_next = cnt;
    if (enable) begin
      cnt_next = tc ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexing controller for a 4-digit 7-segment display. Drives the
// nibble mux (data inputs and select) and the digit anodes, with a blanking
// guard at the start of every slot so a digit is never lit with the
// previous digit's segments.
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   enable         : 1 scans, 0 freezes the scan and darkens all anodes
//   load, dado_in  : one-cycle strobe capturing four nibbles into the shadow
//   digit_mask     : bit i = 1 keeps digit i dark
//   d0..d3         : committed nibbles for mux inputs in0..in3
//   sel            : current digit index for the mux select
//   anodo          : one-hot digit enable, polarity from AN_ACTIVE_LOW
//   fim_quadro     : one-cycle pulse after the last slot of a frame
//   pendente       : shadow holds data not yet committed to d0..d3
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIV           = 50000,
  parameter int BLANK         = 500,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                load,
  input  logic [15:0]         dado_in,
  input  logic [N_DIGITS-1:0] digit_mask,
  output logic [3:0]          d0,
  output logic [3:0]          d1,
  output logic [3:0]          d2,
  output logic [3:0]          d3,
  output logic [1:0]          sel,
  output logic [N_DIGITS-1:0] anodo,
  output logic                fim_quadro,
  output logic                pendente
);

  localparam int CW = $clog2(DIV);
  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW}};

  if (DIV < 2) begin : g_bad_div
    $error("display_scan_ctrl: DIV must be at least 2");
  end
  if (BLANK < 0 || BLANK >= DIV) begin : g_bad_blank
    $error("display_scan_ctrl: BLANK must satisfy 0 <= BLANK < DIV");
  end

  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_next;
  logic                tc;
  digit_idx_t          sel_next;
  logic                frame_end;
  logic                in_window;
  logic [N_DIGITS-1:0] an_next;
  frame_t              shadow;
  frame_t              committed;

  scan_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .cnt    (cnt),
    .tc     (tc)
  );

  // The anode register must line up with sel on the same edge, so it is fed
  // from the next-state count and index rather than the current ones.
  always_comb begin
    cnt_next = cnt;
    if (enable) begin
      cnt_next = tc ? '0 : cnt + CW'(1);
    end
  end

  assign sel_next  = tc ? sel + 2'd1 : sel;
  assign frame_end = tc && (sel == 2'd3);

  // With no blanking every count is inside the active window; the generate
  // split keeps an always-true unsigned compare out of the netlist.
  if (BLANK == 0) begin : g_no_blank
    assign in_window = 1'b1;
  end else begin : g_blank
    localparam logic [CW-1:0] BLANK_W = CW'(BLANK);
    assign in_window = (cnt_next >= BLANK_W);
  end

  always_comb begin
    an_next = AN_OFF;
    if (enable && in_window && !digit_mask[sel_next]) begin
      an_next = an_onehot(sel_next, AN_ACTIVE_LOW);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel        <= 2'd0;
      anodo      <= AN_OFF;
      fim_quadro <= 1'b0;
      shadow     <= '0;
      committed  <= '0;
      pendente   <= 1'b0;
    end else begin
      sel        <= sel_next;
      anodo      <= an_next;
      fim_quadro <= frame_end;

      // Committing only at the frame boundary keeps all four digits from
      // the same load visible together (no tearing within a frame).
      if (frame_end && pendente) begin
        committed <= shadow;
      end

      // A load on the commit edge still wins the shadow: the commit above
      // already took the old contents, and the new data waits a frame.
      if (load) begin
        shadow   <= dado_in;
        pendente <= 1'b1;
      end else if (frame_end) begin
        pendente <= 1'b0;
      end
    end
  end

  assign d0 = committed[0*NIBBLE_W +: NIBBLE_W];
  assign d1 = committed[1*NIBBLE_W +: NIBBLE_W];
  assign d2 = committed[2*NIBBLE_W +: NIBBLE_W];
  assign d3 = committed[3*NIBBLE_W +: NIBBLE_W];

endmodule
